// File: rtl/spi_bus_arbiter_pkg.sv
// ============================================================================
//  Module   : spi_bus_arbiter_pkg
//  Purpose  : Shared state encodings for the SPI bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_bus_arbiter_pkg;

    localparam int c_ST_W = 3;

    localparam logic [c_ST_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_ISSUE     = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_DONE = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_ACKS      = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_HOLD      = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_RELEASE   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_pick.sv
// ============================================================================
//  Module   : spi_bus_arbiter_rr_pick
//  Purpose  : Combinational round-robin picker: first set request at or after
//             ptr, searching upward with wrap.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_bus_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int w_dist;
    int w_best;

    // Each requester's distance from ptr (mod NREQ); the smallest distance wins.
    always_comb begin
        idx    = '0;
        w_best = NREQ;
        w_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = IDXW'(i);
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
// ============================================================================
//  Module   : spi_bus_arbiter
//  Purpose  : Shares one byte-level SPI engine between NREQ requesters with
//             transaction-granular round-robin grants and a hold timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int IDXW         = 1,
    parameter int TOW          = 8,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ-1:0]   LAST,
    input  logic [8*NREQ-1:0] TXD,
    output logic [NREQ-1:0]   ACK,
    output logic [NREQ-1:0]   ABORT,
    output logic [7:0]        RXD,
    output logic [IDXW-1:0]   OWNER,
    output logic              BUSY,
    output logic              ENG_START,
    output logic [7:0]        ENG_TXD,
    output logic              ENG_KEEP,
    output logic              ENG_RELEASE,
    input  logic              ENG_BUSY,
    input  logic              ENG_DONE,
    input  logic [7:0]        ENG_RXD
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_next_state;
    logic [IDXW-1:0]   r_owner;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   w_pick_idx;
    logic [IDXW-1:0]   w_next_ptr;
    logic              w_pick_any;
    logic              r_last_q;
    logic [TOW-1:0]    r_timer;
    logic [7:0]        r_rxd;
    logic [7:0]        w_own_txd;
    logic              w_own_last;
    logic              w_own_req;
    logic              w_timeout;
    logic [NREQ-1:0]   w_owner_oh;

    spi_bus_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req (REQ),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_own_txd  = '0;
        w_own_last = 1'b0;
        w_own_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDXW'(i)) begin
                w_own_txd  = TXD[8*i +: 8];
                w_own_last = LAST[i];
                w_own_req  = REQ[i];
            end
        end
    end

    assign w_owner_oh = NREQ'(1) << r_owner;
    assign w_next_ptr = (r_owner == IDXW'(NREQ - 1)) ? '0 : (r_owner + 1'b1);
    assign w_timeout  = (r_timer == TOW'(HOLD_TIMEOUT));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:      if (w_pick_any) w_next_state = c_ST_ISSUE;
            c_ST_ISSUE:     if (!ENG_BUSY)  w_next_state = c_ST_WAIT_DONE;
            c_ST_WAIT_DONE: if (ENG_DONE)   w_next_state = c_ST_ACKS;
            c_ST_ACKS:      w_next_state = r_last_q ? c_ST_IDLE : c_ST_HOLD;
            c_ST_HOLD: begin
                if (w_own_req)      w_next_state = c_ST_ISSUE;
                else if (w_timeout) w_next_state = c_ST_RELEASE;
            end
            c_ST_RELEASE:   w_next_state = c_ST_IDLE;
            default:        w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        ENG_START   = 1'b0;
        ENG_TXD     = '0;
        ENG_KEEP    = 1'b0;
        ENG_RELEASE = 1'b0;
        ACK         = '0;
        ABORT       = '0;
        case (r_state)
            c_ST_ISSUE: begin
                if (!ENG_BUSY) begin
                    ENG_START = 1'b1;
                    ENG_TXD   = w_own_txd;
                    ENG_KEEP  = !w_own_last;
                end
            end
            c_ST_ACKS:    ACK = w_owner_oh;
            c_ST_HOLD:    if (!w_own_req && w_timeout) ABORT = w_owner_oh;
            c_ST_RELEASE: ENG_RELEASE = 1'b1;
            default: ;
        endcase
    end

    // Owner, pointer, timer and received byte only move on state-specific events.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_last_q <= 1'b0;
            r_timer  <= '0;
            r_rxd    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE:      if (w_pick_any) r_owner <= w_pick_idx;
                c_ST_ISSUE:     if (!ENG_BUSY) r_last_q <= w_own_last;
                c_ST_WAIT_DONE: if (ENG_DONE) r_rxd <= ENG_RXD;
                c_ST_ACKS: begin
                    if (r_last_q) r_rr_ptr <= w_next_ptr;
                    else          r_timer  <= '0;
                end
                c_ST_HOLD:      if (!w_own_req && !w_timeout) r_timer <= r_timer + 1'b1;
                c_ST_RELEASE:   r_rr_ptr <= w_next_ptr;
                default: ;
            endcase
        end
    end

    assign RXD   = r_rxd;
    assign OWNER = r_owner;
    assign BUSY  = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
// ============================================================================
//  Module   : tb_spi_bus_arbiter
//  Purpose  : Directed scenarios plus randomized multi-requester traffic for
//             spi_bus_arbiter, checked against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_bus_arbiter;

    localparam int NREQ         = 2;
    localparam int IDXW         = 1;
    localparam int TOW          = 8;
    localparam int HOLD_TIMEOUT = 4;
    localparam int RAND_LIMIT   = 20000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [1:0]  REQ = '0;
    logic [1:0]  LAST = '0;
    logic [15:0] TXD = '0;
    logic [1:0]  ACK;
    logic [1:0]  ABORT;
    logic [7:0]  RXD;
    logic [0:0]  OWNER;
    logic        BUSY;
    logic        ENG_START;
    logic [7:0]  ENG_TXD;
    logic        ENG_KEEP;
    logic        ENG_RELEASE;
    logic        ENG_BUSY = 1'b0;
    logic        ENG_DONE = 1'b0;
    logic [7:0]  ENG_RXD = '0;

    int checks = 0;
    int failures = 0;

    // Random-phase state
    logic [7:0] qd [NREQ][$];
    bit         ql [NREQ][$];
    logic [7:0] ed [$];
    int         eo [$];
    bit         ek [$];
    int         pos [NREQ];
    int         gap [NREQ];
    bit         upd [NREQ];
    bit         req_m [NREQ];
    bit         last_m [NREQ];
    logic [7:0] txd_m [NREQ];
    int ptr, own, ntr, nb, cyc, eng_left, ack_own, cur_own, waited;
    bit ack_due, ack_next, was_last;
    logic [7:0] ack_rxd, cur_rxd, e_d, dummy_d;
    int e_o;
    bit e_k, dummy_l;

    always #5 CLK = ~CLK;

    spi_bus_arbiter #(
        .NREQ(NREQ), .IDXW(IDXW), .TOW(TOW), .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LAST(LAST), .TXD(TXD),
        .ACK(ACK), .ABORT(ABORT), .RXD(RXD), .OWNER(OWNER), .BUSY(BUSY),
        .ENG_START(ENG_START), .ENG_TXD(ENG_TXD), .ENG_KEEP(ENG_KEEP),
        .ENG_RELEASE(ENG_RELEASE), .ENG_BUSY(ENG_BUSY), .ENG_DONE(ENG_DONE),
        .ENG_RXD(ENG_RXD)
    );

    function automatic logic [1:0] oh(input int i);
        return (i == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ack"}, ACK, 0);
        chk({tag, "_abort"}, ABORT, 0);
        chk({tag, "_rxd"}, RXD, 0);
        chk({tag, "_owner"}, OWNER, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_start"}, ENG_START, 0);
        chk({tag, "_etxd"}, ENG_TXD, 0);
        chk({tag, "_keep"}, ENG_KEEP, 0);
        chk({tag, "_release"}, ENG_RELEASE, 0);
    endtask

    task automatic do_reset();
        nxt();
        RST_N = 1'b0; REQ = '0; LAST = '0; TXD = '0;
        ENG_BUSY = 1'b0; ENG_DONE = 1'b0; ENG_RXD = '0;
        nxt();
        RST_N = 1'b1;
        #1 chk_idle("reset");
    endtask

    // Waits for the start of one byte, checks it, plays the engine, checks the ACK.
    task automatic serve(input string tag, input int o, input logic [7:0] txd,
                         input logic keep, input logic [7:0] rxd, input int delay,
                         output int n);
        n = 0;
        ENG_BUSY = 1'b0;
        ENG_DONE = 1'b0;
        #1;
        while (!ENG_START && n < 40) begin
            nxt();
            #1;
            n++;
        end
        chk({tag, "_start"}, ENG_START, 1);
        if (!ENG_START) return;
        chk({tag, "_owner"}, OWNER, o);
        chk({tag, "_etxd"}, ENG_TXD, txd);
        chk({tag, "_keep"}, ENG_KEEP, keep);
        for (int d = 1; d <= delay; d++) begin
            nxt();
            ENG_BUSY = 1'b1;
            ENG_DONE = (d == delay);
            ENG_RXD  = (d == delay) ? rxd : 8'hEE;
            #1 chk({tag, "_early_ack"}, ACK, 0);
        end
        nxt();
        ENG_BUSY = 1'b0;
        ENG_DONE = 1'b0;
        ENG_RXD  = '0;
        #1;
        chk({tag, "_ack"}, ACK, oh(o));
        chk({tag, "_rxd"}, RXD, rxd);
        chk({tag, "_abort"}, ABORT, 0);
    endtask

    initial begin
        do_reset();

        // 1: single LAST byte from requester 0
        nxt(); REQ = 2'b01; TXD[7:0] = 8'hA5; LAST = 2'b01;
        serve("t1", 0, 8'hA5, 1'b0, 8'h3C, 2, waited);
        chk("t1_latency", waited, 1);
        nxt(); REQ = 2'b00;
        #1;
        chk("t1_idle_busy", BUSY, 0);
        chk("t1_rxd_held", RXD, 8'h3C);

        // 2: both request from reset; alternate owners
        do_reset();
        nxt(); REQ = 2'b11; LAST = 2'b11; TXD = {8'h02, 8'h01};
        serve("t2a", 0, 8'h01, 1'b0, 8'hC1, 1, waited);
        nxt(); TXD[7:0] = 8'h03;
        serve("t2b", 1, 8'h02, 1'b0, 8'hC2, 3, waited);
        nxt(); REQ = 2'b01;
        serve("t2c", 0, 8'h03, 1'b0, 8'hC3, 1, waited);
        nxt(); REQ = 2'b00;

        // 3: requester 1 holds the bus over three bytes
        nxt(); REQ = 2'b11; LAST = 2'b01; TXD = {8'h11, 8'h44};
        serve("t3a", 1, 8'h11, 1'b1, 8'hD1, 2, waited);
        nxt(); TXD[15:8] = 8'h22;
        serve("t3b", 1, 8'h22, 1'b1, 8'hD2, 1, waited);
        nxt(); TXD[15:8] = 8'h33; LAST = 2'b11;
        serve("t3c", 1, 8'h33, 1'b0, 8'hD3, 2, waited);
        nxt(); REQ = 2'b01;
        serve("t3d", 0, 8'h44, 1'b0, 8'hD4, 1, waited);
        nxt(); REQ = 2'b00;

        // 4: stalled owner is aborted after the hold timeout
        nxt(); REQ = 2'b01; LAST = 2'b00; TXD[7:0] = 8'h55;
        serve("t4", 0, 8'h55, 1'b1, 8'hE5, 1, waited);
        nxt(); REQ = 2'b00;
        for (int i = 1; i <= HOLD_TIMEOUT + 1; i++) begin
            #1;
            chk("t4_abort", ABORT, (i == HOLD_TIMEOUT + 1) ? 2'b01 : 2'b00);
            chk("t4_hold_start", ENG_START, 0);
            chk("t4_hold_ack", ACK, 0);
            if (i <= HOLD_TIMEOUT) nxt();
        end
        nxt(); #1;
        chk("t4_release", ENG_RELEASE, 1);
        chk("t4_rel_abort", ABORT, 0);
        nxt(); #1;
        chk("t4_idle_busy", BUSY, 0);
        chk("t4_idle_release", ENG_RELEASE, 0);
        nxt(); REQ = 2'b11; LAST = 2'b11; TXD = {8'h57, 8'h56};
        serve("t4_rr", 1, 8'h57, 1'b0, 8'hE6, 1, waited);
        nxt(); REQ = 2'b01;
        serve("t4_rr0", 0, 8'h56, 1'b0, 8'hE7, 1, waited);
        nxt(); REQ = 2'b00;

        // 5: engine busy on ISSUE entry delays the start
        nxt(); REQ = 2'b01; LAST = 2'b01; TXD[7:0] = 8'h5A;
        #1;
        for (int i = 0; i < 10; i++) begin
            nxt(); ENG_BUSY = 1'b1;
            #1 chk("t5_no_start", ENG_START, 0);
        end
        nxt();
        serve("t5", 0, 8'h5A, 1'b0, 8'hA0, 2, waited);
        chk("t5_latency", waited, 0);
        nxt(); REQ = 2'b00;

        // 6: reset during WAIT_DONE drops the byte
        nxt(); REQ = 2'b11; LAST = 2'b11; TXD = {8'h77, 8'h66};
        #1;
        nxt(); #1;
        chk("t6_start", ENG_START, 1);
        chk("t6_owner", OWNER, 1);
        nxt(); ENG_BUSY = 1'b1; RST_N = 1'b0;
        nxt(); RST_N = 1'b1; ENG_BUSY = 1'b0; ENG_DONE = 1'b1; ENG_RXD = 8'h99;
        #1 chk_idle("t6_rst");
        nxt();
        serve("t6_after", 0, 8'h66, 1'b0, 8'hB6, 1, waited);
        chk("t6_latency", waited, 0);
        nxt(); REQ = 2'b10;
        serve("t6_after1", 1, 8'h77, 1'b0, 8'hB7, 2, waited);
        nxt(); REQ = 2'b00;

        // Random traffic: build per-requester transactions and the expected grant order.
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            ntr = $urandom_range(3, 6);
            for (int t = 0; t < ntr; t++) begin
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    qd[r].push_back(8'($urandom));
                    ql[r].push_back(b == nb - 1);
                end
            end
            pos[r] = 0; gap[r] = 0; upd[r] = 1'b0;
        end
        ptr = 0;
        while (pos[0] < qd[0].size() || pos[1] < qd[1].size()) begin
            own = -1;
            for (int k = 0; k < NREQ; k++)
                if (own < 0 && pos[(ptr + k) % NREQ] < qd[(ptr + k) % NREQ].size())
                    own = (ptr + k) % NREQ;
            do begin
                ed.push_back(qd[own][pos[own]]);
                eo.push_back(own);
                ek.push_back(!ql[own][pos[own]]);
                pos[own]++;
            end while (!ql[own][pos[own] - 1]);
            ptr = (own + 1) % NREQ;
        end

        cyc = 0; eng_left = 0; ack_due = 1'b0; ack_own = 0; cur_own = 0;
        ack_rxd = '0; cur_rxd = '0;
        while ((ed.size() > 0 || ack_due || eng_left > 0) && cyc < RAND_LIMIT) begin
            nxt();
            cyc++;
            for (int r = 0; r < NREQ; r++) begin
                if (upd[r]) begin
                    upd[r]   = 1'b0;
                    was_last = ql[r][0];
                    dummy_d  = qd[r].pop_front();
                    dummy_l  = ql[r].pop_front();
                    if (!was_last) gap[r] = $urandom_range(0, 3);
                end
                if (gap[r] > 0) begin
                    req_m[r] = 1'b0;
                    gap[r]--;
                end else begin
                    req_m[r] = (qd[r].size() > 0);
                end
                if (qd[r].size() > 0) begin
                    txd_m[r]  = qd[r][0];
                    last_m[r] = ql[r][0];
                end
            end
            REQ  = {req_m[1], req_m[0]};
            LAST = {last_m[1], last_m[0]};
            TXD  = {txd_m[1], txd_m[0]};
            ack_next = 1'b0;
            if (eng_left > 0) begin
                ENG_BUSY = 1'b1;
                ENG_DONE = (eng_left == 1);
                ENG_RXD  = (eng_left == 1) ? cur_rxd : 8'($urandom);
                ack_next = (eng_left == 1);
                eng_left--;
            end else begin
                ENG_BUSY = ($urandom_range(0, 5) == 0);
                ENG_DONE = ($urandom_range(0, 7) == 0);
                ENG_RXD  = 8'($urandom);
            end
            #1;
            chk("rand_start_busy", {31'd0, ENG_START & ENG_BUSY}, 0);
            chk("rand_abort", ABORT, 0);
            if (ack_due) begin
                chk("rand_ack", ACK, oh(ack_own));
                chk("rand_rxd", RXD, ack_rxd);
                upd[ack_own] = 1'b1;
            end else begin
                chk("rand_no_ack", ACK, 0);
            end
            ack_due = ack_next;
            if (ack_next) begin
                ack_own = cur_own;
                ack_rxd = cur_rxd;
            end
            if (ENG_START) begin
                if (ed.size() == 0) begin
                    chk("rand_extra_start", ENG_START, 0);
                end else begin
                    e_d = ed.pop_front(); e_o = eo.pop_front(); e_k = ek.pop_front();
                    chk("rand_owner", OWNER, e_o);
                    chk("rand_etxd", ENG_TXD, e_d);
                    chk("rand_keep", ENG_KEEP, e_k);
                    cur_own  = e_o;
                    cur_rxd  = 8'($urandom);
                    eng_left = $urandom_range(1, 4);
                end
            end
        end
        chk("rand_drained", ed.size(), 0);
        chk("rand_in_budget", {31'd0, cyc < RAND_LIMIT}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
